// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: fetches 32-bit words, splits them into fields and walks the PC.
// Optional single-step mode is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_i,
`endif
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_req_o,
  input  logic              imem_valid_i,
  input  logic [31:0]       imem_data_i,
  input  logic              jump_enable_i,
  input  logic              finaliza_execucao_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [7:0]        opcode_o,
  output logic [7:0]        reg1_sel_o,
  output logic [7:0]        reg2_sel_o,
  output logic [7:0]        imm_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_STEP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      S_FETCH: if (imem_valid_i) begin
        instr_d = imem_data_i;
        state_d = S_EXEC;
      end
      // halt keeps pc on the halting instruction and beats a simultaneous jump
      S_EXEC: begin
        if (finaliza_execucao_i) begin
          state_d = S_HALT;
        end else begin
          pc_d = jump_enable_i ? jump_target_i : pc_q + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
          state_d = S_STEP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT:  state_d = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      S_STEP:  if (step_i) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decode straight from state so an async reset drops imem_req immediately
  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_EXEC);
  assign halted_o      = (state_q == S_HALT);
  assign pc_o          = pc_q;
  assign opcode_o      = instr_q[31:24];
  assign reg1_sel_o    = instr_q[23:16];
  assign reg2_sel_o    = instr_q[15:8];
  assign imm_o         = instr_q[7:0];

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed programs plus randomized runs against a program-level model.
module tb_instr_fetch_sequencer;
  localparam int AW = 8;
`ifdef SEQ_SINGLE_STEP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_i = 1'b0;
`endif
  logic [AW-1:0] imem_addr_o;
  logic          imem_req_o;
  logic          imem_valid_i = 1'b0;
  logic [31:0]   imem_data_i = '0;
  logic          jump_enable_i = 1'b0;
  logic          finaliza_execucao_i = 1'b0;
  logic [AW-1:0] jump_target_i = '0;
  logic [7:0]    opcode_o, reg1_sel_o, reg2_sel_o, imm_o;
  logic          instr_valid_o;
  logic [AW-1:0] pc_o;
  logic          halted_o;

  instr_fetch_sequencer #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
`ifdef SEQ_SINGLE_STEP_EN
    .step_i(step_i),
`endif
    .imem_addr_o(imem_addr_o), .imem_req_o(imem_req_o),
    .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
    .jump_enable_i(jump_enable_i), .finaliza_execucao_i(finaliza_execucao_i),
    .jump_target_i(jump_target_i),
    .opcode_o(opcode_o), .reg1_sel_o(reg1_sel_o), .reg2_sel_o(reg2_sel_o), .imm_o(imm_o),
    .instr_valid_o(instr_valid_o), .pc_o(pc_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // program image and what the decoder says about each address
  logic [31:0]   mem    [256];
  bit            halt_at[256];
  bit            jump_at[256];
  logic [AW-1:0] tgt_at [256];
  logic [31:0]   cur_f;
  bit            step_rand = 0;
  logic [AW-1:0] trace[$];
  int            exec_cyc[$];

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0100_0000 | 32'(i); halt_at[i] = 0; jump_at[i] = 0; tgt_at[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; start_i = 0; imem_valid_i = 0; jump_enable_i = 0; finaliza_execucao_i = 0;
`ifdef SEQ_SINGLE_STEP_EN
    step_i = 0;
`endif
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    cur_f = '0;
  endtask

  // Runs the loaded program from reset to HALT, checking the DUT every cycle.
  task automatic run_prog(input int wmin, input int wmax, input int limit, input int budget);
    logic [AW-1:0] exp_pc;
    int wait_left, n, cyc;
    bit in_fetch, halt_exp, done;
    exp_pc = 8'h00; wait_left = 0; n = 0; cyc = 0; in_fetch = 0; halt_exp = 0; done = 0;
    trace.delete(); exec_cyc.delete();
    start_i = 1'b1;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      start_i = 1'($urandom_range(0, 1));
      imem_valid_i = 0; imem_data_i = $urandom;
      jump_enable_i = 1'($urandom_range(0, 1));
      finaliza_execucao_i = 1'($urandom_range(0, 1));
      jump_target_i = AW'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
      step_i = step_rand ? 1'($urandom_range(0, 1)) : 1'b1;
`endif
      total++;
      if ({opcode_o, reg1_sel_o, reg2_sel_o, imm_o} !== cur_f) begin
        bad++; $display("FAIL fields: got %h want %h cyc %0d", {opcode_o, reg1_sel_o, reg2_sel_o, imm_o}, cur_f, cyc);
      end
      if (halt_exp) begin
        total++;
        if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || pc_o !== exp_pc) begin
          bad++; $display("FAIL halt_entry: halted=%b req=%b iv=%b pc=%h want pc=%h", halted_o, imem_req_o, instr_valid_o, pc_o, exp_pc);
        end
        done = 1;
      end else if (imem_req_o === 1'b1) begin
        total++;
        if (imem_addr_o !== exp_pc || pc_o !== exp_pc || instr_valid_o !== 1'b0 || halted_o !== 1'b0) begin
          bad++; $display("FAIL fetch: addr=%h pc=%h iv=%b halted=%b want addr=%h", imem_addr_o, pc_o, instr_valid_o, halted_o, exp_pc);
        end
        if (!in_fetch) begin in_fetch = 1; wait_left = $urandom_range(wmin, wmax); end
        if (wait_left == 0) begin
          imem_valid_i = 1; imem_data_i = mem[exp_pc]; cur_f = mem[exp_pc]; in_fetch = 0;
        end else wait_left--;
      end else if (instr_valid_o === 1'b1) begin
        total++;
        if (pc_o !== exp_pc || halted_o !== 1'b0) begin
          bad++; $display("FAIL exec_pc: pc=%h halted=%b want pc=%h", pc_o, halted_o, exp_pc);
        end
        trace.push_back(exp_pc); exec_cyc.push_back(cyc); n++;
        finaliza_execucao_i = halt_at[exp_pc] || (n >= limit);
        jump_enable_i = jump_at[exp_pc];
        jump_target_i = tgt_at[exp_pc];
        imem_valid_i = 1'($urandom_range(0, 1));
        if (finaliza_execucao_i) halt_exp = 1;
        else if (jump_enable_i) exp_pc = tgt_at[exp_pc];
        else exp_pc = exp_pc + 8'd1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      else if (halted_o === 1'b0) begin
        total++;
        if (pc_o !== exp_pc) begin
          bad++; $display("FAIL step_pc: pc=%h want %h", pc_o, exp_pc);
        end
      end
`endif
      else begin
        bad++; $display("FAIL state: unexpected req=%b iv=%b halted=%b at cyc %0d", imem_req_o, instr_valid_o, halted_o, cyc);
        done = 1;
      end
    end
    if (!done) begin
      total++; bad++; $display("FAIL timeout: program did not halt in %0d cycles", budget);
    end
    repeat (4) begin
      @(negedge clk);
      start_i = 1; imem_valid_i = 1'($urandom_range(0, 1));
      total++;
      if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== exp_pc) begin
        bad++; $display("FAIL halt_hold: halted=%b req=%b pc=%h want pc=%h", halted_o, imem_req_o, pc_o, exp_pc);
      end
    end
    start_i = 0; imem_valid_i = 0;
  endtask

  task automatic check_trace(input string name, input logic [AW-1:0] exp[$]);
    total++;
    if (trace != exp) begin
      bad++; $display("FAIL %s_trace: got %p want %p", name, trace, exp);
    end
  endtask

  task automatic check_period(input string name, input int per);
    for (int i = 1; i < exec_cyc.size(); i++) begin
      total++;
      if (exec_cyc[i] - exec_cyc[i-1] != per) begin
        bad++; $display("FAIL %s_period: got %0d want %0d", name, exec_cyc[i] - exec_cyc[i-1], per);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (imem_req_o !== 0 || instr_valid_o !== 0 || halted_o !== 0 || pc_o !== 8'h00 ||
        {opcode_o, reg1_sel_o, reg2_sel_o, imm_o} !== 32'h0) begin
      bad++; $display("FAIL reset_state: req=%b iv=%b halted=%b pc=%h", imem_req_o, instr_valid_o, halted_o, pc_o);
    end
    start_i = 1; @(negedge clk); start_i = 0;
    imem_valid_i = 1; imem_data_i = 32'h0500_0000; @(negedge clk); imem_valid_i = 0;
    jump_enable_i = 1; jump_target_i = 8'h55; @(negedge clk); jump_enable_i = 0;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 8'h55) begin
      bad++; $display("FAIL reset_prefetch: req=%b addr=%h want 1/55", imem_req_o, imem_addr_o);
    end
    #2 rst_ni = 0;
    #1 total++;
    if (imem_req_o !== 0 || pc_o !== 8'h00 || halted_o !== 0 || instr_valid_o !== 0 ||
        {opcode_o, reg1_sel_o, reg2_sel_o, imm_o} !== 32'h0) begin
      bad++; $display("FAIL reset_async: req=%b pc=%h halted=%b iv=%b", imem_req_o, pc_o, halted_o, instr_valid_o);
    end
    @(negedge clk); rst_ni = 1; cur_f = '0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (imem_req_o !== 0 || instr_valid_o !== 0 || halted_o !== 0) begin
        bad++; $display("FAIL reset_idle: req=%b iv=%b halted=%b", imem_req_o, instr_valid_o, halted_o);
      end
    end
  endtask

  task automatic test_program();
    clear_prog();
    mem[0] = 32'h0001_0005; mem[1] = 32'h0901_0200; mem[2] = 32'h0F00_0000; halt_at[2] = 1;
    do_reset(); run_prog(0, 0, 100, 200);
    check_trace("program", '{8'h00, 8'h01, 8'h02});
    check_period("program", 2 + EXTRA);
  endtask

  task automatic test_jump();
    clear_prog();
    mem[3] = 32'h0500_0020; jump_at[3] = 1; tgt_at[3] = 8'h20; halt_at[8'h20] = 1;
    do_reset(); run_prog(0, 1, 100, 300);
    check_trace("jump", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20});
    halt_at[3] = 1;
    do_reset(); run_prog(0, 1, 100, 300);
    check_trace("jump_halt", '{8'h00, 8'h01, 8'h02, 8'h03});
  endtask

  task automatic test_wrap();
    clear_prog();
    jump_at[0] = 1; tgt_at[0] = 8'hFF;
    do_reset(); run_prog(0, 0, 4, 200);
    check_trace("wrap", '{8'h00, 8'hFF, 8'h00, 8'hFF});
  endtask

  task automatic test_wait_states();
    clear_prog();
    for (int i = 0; i < 6; i++) mem[i] = $urandom;
    halt_at[5] = 1;
    do_reset(); run_prog(3, 3, 100, 400);
    check_trace("wait", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    check_period("wait", 5 + EXTRA);
  endtask

  task automatic test_random();
    step_rand = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = $urandom; halt_at[i] = ($urandom_range(0, 19) == 0);
        jump_at[i] = ($urandom_range(0, 5) == 0); tgt_at[i] = AW'($urandom);
      end
      do_reset(); run_prog(0, 4, 30, 3000);
    end
    step_rand = 0;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    start_i = 1; @(negedge clk); start_i = 0;
    imem_valid_i = 1; imem_data_i = 32'h0102_0304; @(negedge clk); imem_valid_i = 0;
    @(negedge clk);
    repeat (6) begin
      total++;
      if (pc_o !== 8'h01 || imem_req_o !== 0 || instr_valid_o !== 0 || halted_o !== 0) begin
        bad++; $display("FAIL step_hold: pc=%h req=%b iv=%b want pc=01", pc_o, imem_req_o, instr_valid_o);
      end
      @(negedge clk);
    end
    step_i = 1; @(negedge clk); step_i = 0;
    total++;
    if (imem_req_o !== 1 || imem_addr_o !== 8'h01) begin
      bad++; $display("FAIL step_fetch: req=%b addr=%h want 1/01", imem_req_o, imem_addr_o);
    end
    imem_valid_i = 1; imem_data_i = 32'h0A0B_0C0D; @(negedge clk); imem_valid_i = 0;
    total++;
    if (instr_valid_o !== 1 || pc_o !== 8'h01 || opcode_o !== 8'h0A) begin
      bad++; $display("FAIL step_exec: iv=%b pc=%h op=%h want 1/01/0A", instr_valid_o, pc_o, opcode_o);
    end
    @(negedge clk);
    repeat (4) begin
      total++;
      if (pc_o !== 8'h02 || imem_req_o !== 0 || instr_valid_o !== 0) begin
        bad++; $display("FAIL step_once: pc=%h req=%b iv=%b want pc=02", pc_o, imem_req_o, instr_valid_o);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_jump();
    test_wrap();
    test_wait_states();
    test_random();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
